// File: rtl/uart_tx_fifo_if.sv
// Byte-in / serial-out port bundle for the UART transmitter.
// The master side is the byte producer; the slave side is the transmitter.
interface uart_tx_fifo_if #(
  parameter int FIFO_DEPTH = 4
);
  logic [7:0]                    data_i;
  logic                          valid_i;
  logic                          ready_o;
  logic                          tx_o;
  logic                          busy_o;
  logic [$clog2(FIFO_DEPTH):0]   level_o;

  modport master (
    output data_i,
    output valid_i,
    input  ready_o,
    input  tx_o,
    input  busy_o,
    input  level_o
  );

  modport slave (
    input  data_i,
    input  valid_i,
    output ready_o,
    output tx_o,
    output busy_o,
    output level_o
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter fed by a small byte FIFO; the first byte reaches the line two edges after its push.
// ready_o is !full only, so a sender facing a full FIFO holds its byte until a pop frees an entry.
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 4167,
  parameter int FIFO_DEPTH   = 4
) (
  input logic           clk,
  input logic           resetb,
  uart_tx_fifo_if.slave bus
);
  localparam int              AW       = $clog2(FIFO_DEPTH);
  localparam int              LW       = AW + 1;
  localparam logic [15:0]     CNT_LAST = 16'(CLKS_PER_BIT - 1);
  localparam logic [LW-1:0]   FULL_LVL = LW'(FIFO_DEPTH);
  localparam logic [AW-1:0]   PTR_ONE  = AW'(1);
  localparam logic [LW-1:0]   LVL_ONE  = LW'(1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [15:0]     baud_cnt;
  logic [15:0]     baud_cnt_nxt;
  logic [2:0]      bit_idx;
  logic [2:0]      bit_idx_nxt;
  logic [7:0]      shift;
  logic [7:0]      shift_nxt;
  logic            tx;
  logic            tx_nxt;

  logic [7:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [LW-1:0]   level;

  logic            push;
  logic            pop;
  logic            fifo_empty;
  logic            baud_last;

  assign fifo_empty  = (level == '0);
  assign baud_last   = (baud_cnt == CNT_LAST);
  assign push        = bus.valid_i && bus.ready_o;

  assign bus.ready_o = (level != FULL_LVL);
  assign bus.tx_o    = tx;
  assign bus.busy_o  = (state != IDLE) || !fifo_empty;
  assign bus.level_o = level;

  // Storage needs no reset: pointers and level define which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= bus.data_i;
    end
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      unique case ({push, pop})
        2'b10:   level <= level + LVL_ONE;
        2'b01:   level <= level - LVL_ONE;
        default: level <= level;
      endcase
    end
  end

  // tx_nxt is the line value for the state being occupied now; the flop delays it one cycle.
  always_comb begin
    state_nxt    = state;
    baud_cnt_nxt = baud_cnt;
    bit_idx_nxt  = bit_idx;
    shift_nxt    = shift;
    tx_nxt       = 1'b1;
    pop          = 1'b0;

    unique case (state)
      IDLE: begin
        baud_cnt_nxt = '0;
        if (!fifo_empty) begin
          pop       = 1'b1;
          shift_nxt = mem[rd_ptr];
          state_nxt = START;
        end
      end

      START: begin
        tx_nxt = 1'b0;
        if (baud_last) begin
          baud_cnt_nxt = '0;
          bit_idx_nxt  = '0;
          state_nxt    = DATA;
        end else begin
          baud_cnt_nxt = baud_cnt + 16'd1;
        end
      end

      DATA: begin
        tx_nxt = shift[0];
        if (baud_last) begin
          baud_cnt_nxt = '0;
          shift_nxt    = {1'b0, shift[7:1]};
          if (bit_idx == 3'd7) begin
            state_nxt = STOP;
          end else begin
            bit_idx_nxt = bit_idx + 3'd1;
          end
        end else begin
          baud_cnt_nxt = baud_cnt + 16'd1;
        end
      end

      STOP: begin
        tx_nxt = 1'b1;
        if (baud_last) begin
          baud_cnt_nxt = '0;
          if (!fifo_empty) begin
            pop       = 1'b1;
            shift_nxt = mem[rd_ptr];
            state_nxt = START;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          baud_cnt_nxt = baud_cnt + 16'd1;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      tx       <= 1'b1;
    end else begin
      state    <= state_nxt;
      baud_cnt <= baud_cnt_nxt;
      bit_idx  <= bit_idx_nxt;
      shift    <= shift_nxt;
      tx       <= tx_nxt;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: a serial-line decoder plus per-scenario tasks comparing the line
// against frames built directly from the accepted byte stream.
module tb_uart_tx_fifo;
  localparam int CPB   = 16;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * CPB;

  logic clk    = 1'b0;
  logic resetb = 1'b0;

  uart_tx_fifo_if #(.FIFO_DEPTH(DEPTH)) bus ();

  uart_tx_fifo #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk   (clk),
    .resetb(resetb),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Serial monitor: samples mid-bit on the falling clock edge.
  logic [7:0] rx_q[$];
  int         rx_t[$];
  int         frame_err = 0;
  bit         m_act     = 1'b0;
  int         m_cnt     = 0;
  int         m_start   = 0;
  logic [7:0] m_byte    = 8'h00;

  always @(negedge clk) begin
    cyc++;
    if (!resetb) begin
      m_act = 1'b0;
    end else if (m_act) begin
      m_cnt++;
      if (m_cnt == CPB/2) begin
        if (bus.tx_o !== 1'b0) frame_err++;
      end else if (m_cnt == CPB/2 + 9*CPB) begin
        if (bus.tx_o !== 1'b1) frame_err++;
        rx_q.push_back(m_byte);
        rx_t.push_back(m_start);
        m_act = 1'b0;
      end else if (m_cnt > CPB/2 && ((m_cnt - CPB/2) % CPB) == 0) begin
        m_byte[3'((m_cnt - CPB/2) / CPB - 1)] = bus.tx_o;
      end
    end else if (bus.tx_o === 1'b0) begin
      m_act   = 1'b1;
      m_cnt   = 0;
      m_start = cyc;
    end
  end

  function automatic logic frame_bit(input logic [7:0] d, input int slot);
    if (slot == 0) return 1'b0;
    if (slot >= 9) return 1'b1;
    return d[slot-1];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((bus.busy_o !== 1'b0 || m_act) && n < 5000) begin
      tick();
      n++;
    end
    repeat (CPB) tick();
    checks++;
    if (n >= 5000) begin
      failures++;
      $display("FAIL wait_idle: busy_o=%b still set after %0d cycles, required 0", bus.busy_o, n);
    end
  endtask

  task automatic test_reset();
    resetb      = 1'b0;
    bus.valid_i = 1'b0;
    bus.data_i  = 8'h00;
    for (int i = 0; i < 8; i++) begin
      bus.valid_i = 1'($urandom_range(0, 1));
      bus.data_i  = 8'($urandom);
      tick();
      checks++;
      if ({bus.tx_o, bus.ready_o, bus.busy_o} !== 3'b110 || bus.level_o !== '0) begin
        failures++;
        $display("FAIL reset_outputs: tx/ready/busy=%b level=%0d, required 110 level=0",
                 {bus.tx_o, bus.ready_o, bus.busy_o}, bus.level_o);
      end
    end
    bus.valid_i = 1'b0;
    tick();
    resetb = 1'b1;
    repeat (2 * CPB) tick();
    checks++;
    if (rx_q.size() != 0 || m_act || bus.busy_o !== 1'b0 || bus.tx_o !== 1'b1) begin
      failures++;
      $display("FAIL reset_release: frames=%0d busy=%b tx=%b, required 0 frames, busy 0, tx 1",
               rx_q.size(), bus.busy_o, bus.tx_o);
    end
  endtask

  task automatic test_single();
    logic [7:0] d = 8'h21;
    int werr = 0;
    int busy_at = -1;
    wait_idle();
    rx_q.delete();
    rx_t.delete();
    bus.valid_i = 1'b1;
    bus.data_i  = d;
    tick();
    bus.valid_i = 1'b0;
    bus.data_i  = 8'($urandom);
    checks++;
    if (bus.level_o !== 3'd1 || bus.busy_o !== 1'b1 || bus.tx_o !== 1'b1) begin
      failures++;
      $display("FAIL single_push: level=%0d busy=%b tx=%b, required 1/1/1", bus.level_o, bus.busy_o, bus.tx_o);
    end
    tick();
    checks++;
    if (bus.level_o !== 3'd0 || bus.tx_o !== 1'b1) begin
      failures++;
      $display("FAIL single_pop: level=%0d tx=%b, required 0/1", bus.level_o, bus.tx_o);
    end
    tick();
    for (int i = 0; i < FRAME; i++) begin
      if (bus.tx_o !== frame_bit(d, i / CPB)) werr++;
      if (busy_at < 0 && bus.busy_o === 1'b0) busy_at = i;
      tick();
    end
    checks++;
    if (werr != 0) begin
      failures++;
      $display("FAIL single_wave: %0d wrong line samples, required 0", werr);
    end
    // busy_o drops 160 cycles after the FSM entered START, one cycle before the line's stop bit ends.
    checks++;
    if (busy_at != FRAME - 1) begin
      failures++;
      $display("FAIL single_busy_fall: at sample %0d, required %0d", busy_at, FRAME - 1);
    end
    checks++;
    if (rx_q.size() != 1 || rx_q[0] !== d || frame_err != 0) begin
      failures++;
      $display("FAIL single_decode: frames=%0d byte=%h errs=%0d, required 1 frame of %h, 0 errs",
               rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 8'hxx, frame_err, d);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] b [3] = '{8'h41, 8'h42, 8'h43};
    int werr = 0;
    int n = 0;
    wait_idle();
    rx_q.delete();
    rx_t.delete();
    for (int k = 0; k < 3; k++) begin
      bus.valid_i = 1'b1;
      bus.data_i  = b[k];
      tick();
    end
    bus.valid_i = 1'b0;
    while (bus.tx_o !== 1'b0 && n < 10) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 10) begin
      failures++;
      $display("FAIL b2b_start: tx_o=%b after %0d cycles, required 0", bus.tx_o, n);
    end
    for (int i = 0; i < 3 * FRAME; i++) begin
      if (bus.tx_o !== frame_bit(b[i / FRAME], (i % FRAME) / CPB)) werr++;
      tick();
    end
    checks++;
    if (werr != 0) begin
      failures++;
      $display("FAIL b2b_wave: %0d wrong line samples, required 0", werr);
    end
    wait_idle();
    checks++;
    if (rx_q.size() != 3 || rx_q[0] !== b[0] || rx_q[1] !== b[1] || rx_q[2] !== b[2]) begin
      failures++;
      $display("FAIL b2b_order: got %0d frames, required 41 42 43", rx_q.size());
    end
    checks++;
    if (rx_t.size() != 3 || rx_t[1] - rx_t[0] != FRAME || rx_t[2] - rx_t[1] != FRAME) begin
      failures++;
      $display("FAIL b2b_spacing: frame starts %0d entries, required spacing %0d", rx_t.size(), FRAME);
    end
  endtask

  task automatic test_full_fifo();
    logic [7:0] b [6];
    logic [7:0] exp_q[$];
    int acc = 0;
    int t_push = 0;
    int n = 0;
    logic rdy;
    for (int k = 0; k < 6; k++) b[k] = 8'($urandom);
    wait_idle();
    rx_q.delete();
    rx_t.delete();
    bus.valid_i = 1'b1;
    bus.data_i  = b[0];
    for (int k = 0; k < 10; k++) begin
      rdy = bus.ready_o;
      tick();
      if (rdy) begin
        exp_q.push_back(bus.data_i);
        acc++;
        if (acc == 1) t_push = cyc;
        bus.data_i = b[acc];
      end
    end
    checks++;
    if (acc != 5 || bus.level_o !== 3'd4 || bus.ready_o !== 1'b0) begin
      failures++;
      $display("FAIL full_accept: accepted=%0d level=%0d ready=%b, required 5/4/0", acc, bus.level_o, bus.ready_o);
    end
    while (bus.ready_o !== 1'b1 && n < 400) begin
      tick();
      n++;
    end
    checks++;
    if (cyc - t_push != FRAME + 1) begin
      failures++;
      $display("FAIL full_ready_rise: %0d cycles after first push, required %0d", cyc - t_push, FRAME + 1);
    end
    tick();
    exp_q.push_back(b[5]);
    bus.valid_i = 1'b0;
    checks++;
    if (bus.ready_o !== 1'b0 || bus.level_o !== 3'd4) begin
      failures++;
      $display("FAIL full_refill: ready=%b level=%0d, required 0/4", bus.ready_o, bus.level_o);
    end
    wait_idle();
    checks++;
    if (rx_q.size() != 6 || rx_q != exp_q || frame_err != 0) begin
      failures++;
      $display("FAIL full_order: got %0d frames errs=%0d, required 6 in push order", rx_q.size(), frame_err);
    end
  endtask

  task automatic test_simul_push_pop();
    logic [7:0] b [4];
    logic [7:0] exp_q[$];
    int t_push = 0;
    for (int k = 0; k < 4; k++) b[k] = 8'($urandom);
    wait_idle();
    rx_q.delete();
    rx_t.delete();
    for (int k = 0; k < 3; k++) begin
      bus.valid_i = 1'b1;
      bus.data_i  = b[k];
      tick();
      exp_q.push_back(b[k]);
      if (k == 0) t_push = cyc;
    end
    bus.valid_i = 1'b0;
    while (cyc < t_push + FRAME) tick();
    checks++;
    if (bus.level_o !== 3'd2) begin
      failures++;
      $display("FAIL simul_pre_level: level=%0d, required 2", bus.level_o);
    end
    bus.valid_i = 1'b1;
    bus.data_i  = b[3];
    tick();
    exp_q.push_back(b[3]);
    bus.valid_i = 1'b0;
    checks++;
    if (bus.level_o !== 3'd2) begin
      failures++;
      $display("FAIL simul_level: level=%0d, required 2", bus.level_o);
    end
    wait_idle();
    checks++;
    if (rx_q != exp_q || frame_err != 0) begin
      failures++;
      $display("FAIL simul_order: got %0d frames errs=%0d, required 4 in push order", rx_q.size(), frame_err);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] b [3] = '{8'h55, 8'h11, 8'h22};
    int t_push = 0;
    int lows = 0;
    wait_idle();
    rx_q.delete();
    rx_t.delete();
    for (int k = 0; k < 3; k++) begin
      bus.valid_i = 1'b1;
      bus.data_i  = b[k];
      tick();
      if (k == 0) t_push = cyc;
    end
    bus.valid_i = 1'b0;
    while (cyc < t_push + 2 + 4 * CPB + CPB / 2) tick();
    checks++;
    if (bus.tx_o !== 1'b0 || bus.level_o !== 3'd2) begin
      failures++;
      $display("FAIL mid_bit3: tx=%b level=%0d, required 0/2", bus.tx_o, bus.level_o);
    end
    #2;
    resetb = 1'b0;
    #1;
    checks++;
    if (bus.tx_o !== 1'b1 || bus.level_o !== '0 || bus.busy_o !== 1'b0 || bus.ready_o !== 1'b1) begin
      failures++;
      $display("FAIL mid_reset: tx=%b level=%0d busy=%b ready=%b, required 1/0/0/1",
               bus.tx_o, bus.level_o, bus.busy_o, bus.ready_o);
    end
    tick();
    tick();
    resetb = 1'b1;
    for (int i = 0; i < 2 * FRAME; i++) begin
      if (bus.tx_o !== 1'b1) lows++;
      tick();
    end
    checks++;
    if (lows != 0 || rx_q.size() != 0) begin
      failures++;
      $display("FAIL mid_quiet: %0d low samples, %0d frames, required 0/0", lows, rx_q.size());
    end
    bus.valid_i = 1'b1;
    bus.data_i  = 8'h7E;
    tick();
    bus.valid_i = 1'b0;
    wait_idle();
    checks++;
    if (rx_q.size() != 1 || rx_q[0] !== 8'h7E || frame_err != 0) begin
      failures++;
      $display("FAIL mid_recover: %0d frames errs=%0d, required one 7e", rx_q.size(), frame_err);
    end
  endtask

  task automatic test_random();
    logic [7:0] exp_q[$];
    int bad = 0;
    logic rdy;
    wait_idle();
    rx_q.delete();
    rx_t.delete();
    bus.valid_i = 1'b0;
    for (int i = 0; i < 1200; i++) begin
      if (!bus.valid_i) begin
        bus.data_i = 8'($urandom);
        if ($urandom_range(0, 15) == 0) bus.valid_i = 1'b1;
      end
      rdy = bus.ready_o;
      if (bus.level_o > 3'(DEPTH) || bus.ready_o !== (bus.level_o != 3'(DEPTH))) bad++;
      tick();
      if (bus.valid_i && rdy) begin
        exp_q.push_back(bus.data_i);
        bus.valid_i = 1'b0;
      end
    end
    bus.valid_i = 1'b0;
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL rand_ready_level: %0d inconsistent cycles, required 0", bad);
    end
    wait_idle();
    checks++;
    if (rx_q != exp_q || frame_err != 0) begin
      failures++;
      $display("FAIL rand_stream: got %0d frames errs=%0d, required %0d in push order",
               rx_q.size(), frame_err, exp_q.size());
    end
  endtask

  initial begin
    #5_000_000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    bus.valid_i = 1'b0;
    bus.data_i  = 8'h00;
    test_reset();
    test_single();
    test_back_to_back();
    test_full_fifo();
    test_simul_push_pop();
    test_reset_mid_frame();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
